even_result_pipe: RTL and testbench

//  Parametrised result staging pipeline for the SPU even pipe, generalising the fixed 7-stage packed-result chain.

---
 rtl/even_result_pipe.sv | 128 ++++++++++++
 tb/tb_even_result_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/even_result_pipe.sv
// rtl/even_result_pipe.sv - SPU even-pipe result staging pipeline with latency readiness, forwarding and flush
// Stage 1 is the youngest entry; multi-bit taps and per-port vectors place stage 1 / port 0 in the MSBs.
module even_result_pipe #(
    parameter int NUM_STAGES  = 7,
    parameter int DATA_W      = 128,
    parameter int ADDR_W      = 7,
    parameter int LAT_W       = 4,
    parameter int UNIT_W      = 3,
    parameter int NUM_RD      = 3,
    parameter int FLUSH_DEPTH = 3,
    localparam int PK_W       = DATA_W + ADDR_W + 1 + LAT_W + UNIT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_valid,
    input  logic [DATA_W-1:0]            result,
    input  logic [ADDR_W-1:0]            reg_dst,
    input  logic                         reg_wr,
    input  logic [LAT_W-1:0]             latency,
    input  logic [UNIT_W-1:0]            unit_id,
    input  logic                         flush,
    input  logic [NUM_RD*ADDR_W-1:0]     query_addr,
    output logic [NUM_STAGES*PK_W-1:0]   packed_stage,
    output logic [NUM_STAGES-1:0]        stage_valid,
    output logic [NUM_RD-1:0]            fwd_hit,
    output logic [NUM_RD-1:0]            fwd_pending,
    output logic [NUM_RD*DATA_W-1:0]     fwd_data,
    output logic [ADDR_W-1:0]            WB_reg_write_addr,
    output logic [DATA_W-1:0]            WB_reg_write_data,
    output logic                         WB_reg_write_en
);

    localparam int LAT_LSB = UNIT_W;
    localparam int WR_BIT  = UNIT_W + LAT_W;
    localparam int DST_LSB = WR_BIT + 1;
    localparam int DAT_LSB = DST_LSB + ADDR_W;

    // Internal index 0 is stage 1.
    logic [PK_W-1:0]       pk_q [NUM_STAGES];
    logic [PK_W-1:0]       pk_d [NUM_STAGES];
    logic [NUM_STAGES-1:0] vld_q, vld_d;
    logic [NUM_STAGES-1:0] rdy;
    logic                  wb_en_q, wb_en_d;
    logic [ADDR_W-1:0]     wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]     wb_data_q, wb_data_d;
    int                    lat_v, eff_v;

    always_comb begin
        vld_d[0] = issue_valid & ~flush;
        pk_d[0]  = vld_d[0] ? {result, reg_dst, reg_wr, latency, unit_id} : '0;
        for (int k = 1; k < NUM_STAGES; k++) begin
            if (flush && k <= FLUSH_DEPTH) begin
                vld_d[k] = 1'b0;
                pk_d[k]  = '0;
            end else begin
                vld_d[k] = vld_q[k-1];
                pk_d[k]  = pk_q[k-1];
            end
        end
        wb_en_d   = vld_q[NUM_STAGES-1] & pk_q[NUM_STAGES-1][WR_BIT];
        wb_addr_d = vld_q[NUM_STAGES-1] ? pk_q[NUM_STAGES-1][DST_LSB +: ADDR_W] : '0;
        wb_data_d = vld_q[NUM_STAGES-1] ? pk_q[NUM_STAGES-1][DAT_LSB +: DATA_W] : '0;
    end

    // Latency 0 behaves as 1; anything beyond the pipe depth is ready only in the last stage.
    always_comb begin
        lat_v = 0;
        eff_v = 1;
        rdy   = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            lat_v = int'(pk_q[k][LAT_LSB +: LAT_W]);
            if (lat_v == 0)
                eff_v = 1;
            else if (lat_v > NUM_STAGES)
                eff_v = NUM_STAGES;
            else
                eff_v = lat_v;
            rdy[k] = ((k + 1) >= eff_v);
        end
    end

    // Scan oldest to youngest so the youngest matching stage has the final say.
    always_comb begin
        fwd_hit     = '0;
        fwd_pending = '0;
        fwd_data    = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                if (vld_q[k] && pk_q[k][WR_BIT] &&
                    pk_q[k][DST_LSB +: ADDR_W] == query_addr[(NUM_RD-1-i)*ADDR_W +: ADDR_W]) begin
                    fwd_hit[NUM_RD-1-i]     = rdy[k];
                    fwd_pending[NUM_RD-1-i] = ~rdy[k];
                    fwd_data[(NUM_RD-1-i)*DATA_W +: DATA_W] = rdy[k] ? pk_q[k][DAT_LSB +: DATA_W] : '0;
                end
            end
        end
    end

    always_comb begin
        packed_stage = '0;
        stage_valid  = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            packed_stage[(NUM_STAGES-1-k)*PK_W +: PK_W] = pk_q[k];
            stage_valid[NUM_STAGES-1-k]                 = vld_q[k];
        end
    end

    assign WB_reg_write_en   = wb_en_q;
    assign WB_reg_write_addr = wb_addr_q;
    assign WB_reg_write_data = wb_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_STAGES; k++) pk_q[k] <= '0;
            vld_q     <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) pk_q[k] <= pk_d[k];
            vld_q     <= vld_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

endmodule

// File: tb/tb_even_result_pipe.sv
// tb/tb_even_result_pipe.sv - scoreboard bench for even_result_pipe
module tb_even_result_pipe;

    localparam int NS  = 7;
    localparam int DW  = 128;
    localparam int AW  = 7;
    localparam int LW  = 4;
    localparam int UW  = 3;
    localparam int NR  = 3;
    localparam int PKW = DW + AW + 1 + LW + UW;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_valid;
    logic [DW-1:0]     result;
    logic [AW-1:0]     reg_dst;
    logic              reg_wr;
    logic [LW-1:0]     latency;
    logic [UW-1:0]     unit_id;
    logic              flush;
    logic [NR*AW-1:0]  query_addr;
    logic [NS*PKW-1:0] packed_stage;
    logic [NS-1:0]     stage_valid;
    logic [NR-1:0]     fwd_hit;
    logic [NR-1:0]     fwd_pending;
    logic [NR*DW-1:0]  fwd_data;
    logic [AW-1:0]     WB_reg_write_addr;
    logic [DW-1:0]     WB_reg_write_data;
    logic              WB_reg_write_en;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_t;
    wb_t sb[$];
    wb_t mon_e;

    always #5 clk = ~clk;

    even_result_pipe dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .result(result), .reg_dst(reg_dst),
        .reg_wr(reg_wr), .latency(latency), .unit_id(unit_id), .flush(flush), .query_addr(query_addr),
        .packed_stage(packed_stage), .stage_valid(stage_valid), .fwd_hit(fwd_hit),
        .fwd_pending(fwd_pending), .fwd_data(fwd_data), .WB_reg_write_addr(WB_reg_write_addr),
        .WB_reg_write_data(WB_reg_write_data), .WB_reg_write_en(WB_reg_write_en)
    );

    // Every write-back must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst === 1'b1 && WB_reg_write_en === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got addr=%0d data=%h, required no write", WB_reg_write_addr, WB_reg_write_data);
            end else begin
                mon_e = sb.pop_front();
                if (WB_reg_write_addr !== mon_e.addr || WB_reg_write_data !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL wb_entry: got addr=%0d data=%h, required addr=%0d data=%h",
                             WB_reg_write_addr, WB_reg_write_data, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    function automatic logic [DW-1:0] pat(input logic [7:0] r);
        return {16{r}};
    endfunction

    function automatic logic p_hit(input int i);
        return fwd_hit[NR-1-i];
    endfunction

    function automatic logic p_pend(input int i);
        return fwd_pending[NR-1-i];
    endfunction

    function automatic logic [DW-1:0] p_data(input int i);
        return fwd_data[(NR-1-i)*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        flush       = 1'b0;
        reg_wr      = 1'b0;
        result      = '0;
        reg_dst     = '0;
        latency     = '0;
        unit_id     = '0;
    endtask

    task automatic issue(input logic [AW-1:0] d, input logic [DW-1:0] v, input logic w,
                         input logic [LW-1:0] l, input bit exp_wb);
        wb_t ex;
        issue_valid = 1'b1;
        reg_dst     = d;
        result      = v;
        reg_wr      = w;
        latency     = l;
        unit_id     = 3'd5;
        if (exp_wb) begin
            ex.addr = d;
            ex.data = v;
            sb.push_back(ex);
        end
        tick();
        idle();
    endtask

    task automatic chk_fwd(input string name, input int port, input logic eh, input logic ep, input logic [DW-1:0] ed);
        n_tests++;
        if (p_hit(port) !== eh || p_pend(port) !== ep || p_data(port) !== ed) begin
            n_fail++;
            $display("FAIL %s: got hit=%b pend=%b data=%h, required hit=%b pend=%b data=%h",
                     name, p_hit(port), p_pend(port), p_data(port), eh, ep, ed);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        query_addr = '0;
        #12;
        n_tests++;
        if (stage_valid !== '0 || packed_stage !== '0 || WB_reg_write_en !== 1'b0 ||
            WB_reg_write_addr !== '0 || WB_reg_write_data !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b wb_en=%b, required all zero", stage_valid, WB_reg_write_en);
        end
        rst = 1'b1;
        for (int r = 1; r <= 3; r++) issue(AW'(r + 20), pat(8'(r)), 1'b1, 4'd1, 1'b0);
        n_tests++;
        if (stage_valid !== 7'b1110000) begin
            n_fail++;
            $display("FAIL reset_prefill: got %b, required %b", stage_valid, 7'b1110000);
        end
        #1 rst = 1'b0;
        #1;
        n_tests++;
        if (stage_valid !== '0 || packed_stage !== '0 || WB_reg_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midflight: got valid=%b wb_en=%b, required 0 and 0", stage_valid, WB_reg_write_en);
        end
        #2 rst = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        logic [DW-1:0] d1;
        d1 = pat(8'h11);
        query_addr = {7'd7, 7'd0, 7'd0};
        issue(7'd7, d1, 1'b1, 4'd2, 1'b1);
        chk_fwd("lat_edge1", 0, 1'b0, 1'b1, '0);
        for (int e = 2; e <= 7; e++) begin
            tick();
            chk_fwd($sformatf("lat_edge%0d", e), 0, 1'b1, 1'b0, d1);
        end
        tick();
        n_tests++;
        if (WB_reg_write_en !== 1'b1 || WB_reg_write_addr !== 7'd7 || WB_reg_write_data !== d1) begin
            n_fail++;
            $display("FAIL lat_wb: got en=%b addr=%0d, required en=1 addr=7", WB_reg_write_en, WB_reg_write_addr);
        end
        tick();
    endtask

    task automatic test_youngest();
        query_addr = {7'd5, 7'd0, 7'd0};
        issue(7'd5, pat(8'h5A), 1'b1, 4'd1, 1'b1);
        chk_fwd("yw_a_ready", 0, 1'b1, 1'b0, pat(8'h5A));
        issue(7'd5, pat(8'hB5), 1'b1, 4'd3, 1'b1);
        chk_fwd("yw_b_stage1", 0, 1'b0, 1'b1, '0);
        tick();
        chk_fwd("yw_b_stage2", 0, 1'b0, 1'b1, '0);
        tick();
        chk_fwd("yw_b_stage3", 0, 1'b1, 1'b0, pat(8'hB5));
        repeat (8) tick();
    endtask

    task automatic test_flush();
        query_addr = {7'd1, 7'd4, 7'd0};
        for (int r = 7; r >= 1; r--) issue(AW'(r), pat(8'(r)), 1'b1, 4'd1, r >= 4);
        n_tests++;
        if (stage_valid !== 7'b1111111) begin
            n_fail++;
            $display("FAIL flush_fill: got %b, required %b", stage_valid, 7'b1111111);
        end
        issue_valid = 1'b1;
        flush       = 1'b1;
        reg_dst     = 7'd9;
        reg_wr      = 1'b1;
        result      = pat(8'h09);
        latency     = 4'd1;
        tick();
        idle();
        n_tests++;
        if (stage_valid !== 7'b0000111) begin
            n_fail++;
            $display("FAIL flush_valid: got %b, required %b", stage_valid, 7'b0000111);
        end
        chk_fwd("flush_killed_r1", 0, 1'b0, 1'b0, '0);
        chk_fwd("flush_surv_r4", 1, 1'b1, 1'b0, pat(8'h04));
        repeat (8) tick();
    endtask

    task automatic test_clamp();
        query_addr = {7'd10, 7'd11, 7'd0};
        issue(7'd10, pat(8'h0A), 1'b1, 4'd0, 1'b1);
        chk_fwd("clamp_lat0", 0, 1'b1, 1'b0, pat(8'h0A));
        issue(7'd11, pat(8'h0B), 1'b1, 4'd15, 1'b1);
        for (int e = 1; e <= 6; e++) begin
            chk_fwd($sformatf("clamp_lat15_s%0d", e), 1, 1'b0, 1'b1, '0);
            tick();
        end
        chk_fwd("clamp_lat15_s7", 1, 1'b1, 1'b0, pat(8'h0B));
        repeat (3) tick();
    endtask

    task automatic test_no_write();
        logic [PKW-1:0] exp_pk;
        exp_pk = {pat(8'hAA), 7'd12, 1'b0, 4'd1, 3'd5};
        query_addr = {7'd12, 7'd0, 7'd0};
        issue(7'd12, pat(8'hAA), 1'b0, 4'd1, 1'b0);
        n_tests++;
        if (packed_stage[(NS-1)*PKW +: PKW] !== exp_pk || stage_valid !== 7'b1000000) begin
            n_fail++;
            $display("FAIL nowr_tap: got %h valid=%b, required %h valid=1000000",
                     packed_stage[(NS-1)*PKW +: PKW], stage_valid, exp_pk);
        end
        chk_fwd("nowr_fwd", 0, 1'b0, 1'b0, '0);
        for (int e = 2; e <= 9; e++) begin
            tick();
            n_tests++;
            if (WB_reg_write_en !== 1'b0) begin
                n_fail++;
                $display("FAIL nowr_wb_edge%0d: got en=%b, required 0", e, WB_reg_write_en);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_youngest();
        test_flush();
        test_clamp();
        test_no_write();
        repeat (2) tick();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL wb_missing: got %0d writes outstanding, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
